reorder_buffer: RTL and testbench

Circular in-order retirement buffer between the issue unit, the CDB/LSB writeback buses and the register file. Allocates a tag per issued instruction, captures results out of order, and retires one instruction per cycle in program order through the commit port (commit_valid/commit_index/commit_rd/commit_value) into the register file's ROB inputs. Detects branch mispredictions at commit and broadcasts flush with the redirect PC.

---
 rtl/reorder_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// =====================================================================
// reorder_buffer: circular in-order retirement buffer with flush.
// Rev 1.0
// =====================================================================
module reorder_buffer #(
    parameter int ROB_ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  issue_valid,
    input  logic [1:0]            issue_type,
    input  logic [4:0]            issue_rd,
    input  logic [31:0]           issue_pc,
    input  logic                  issue_pred_jump,
    output logic [ROB_ADDR_W-1:0] issue_index,
    output logic                  rob_full,
    input  logic                  cdb_valid,
    input  logic [ROB_ADDR_W-1:0] cdb_index,
    input  logic [31:0]           cdb_value,
    input  logic                  cdb_jump,
    input  logic [31:0]           cdb_target,
    input  logic                  lsb_valid,
    input  logic [ROB_ADDR_W-1:0] lsb_index,
    input  logic [31:0]           lsb_value,
    input  logic [ROB_ADDR_W-1:0] query1_index,
    output logic                  query1_ready,
    output logic [31:0]           query1_value,
    input  logic [ROB_ADDR_W-1:0] query2_index,
    output logic                  query2_ready,
    output logic [31:0]           query2_value,
    output logic                  commit_valid,
    output logic [ROB_ADDR_W-1:0] commit_index,
    output logic [4:0]            commit_rd,
    output logic [31:0]           commit_value,
    output logic                  commit_store,
    output logic                  flush,
    output logic [31:0]           flush_pc
);

    localparam int                    DEPTH       = 1 << ROB_ADDR_W;
    localparam logic [ROB_ADDR_W:0]   FULL_COUNT  = (ROB_ADDR_W+1)'(DEPTH);
    localparam logic [1:0]            TYPE_BRANCH = 2'd1;
    localparam logic [1:0]            TYPE_STORE  = 2'd2;

    logic                  valid_q  [DEPTH];
    logic                  ready_q  [DEPTH];
    logic [1:0]            type_q   [DEPTH];
    logic [4:0]            rd_q     [DEPTH];
    logic [31:0]           pc_q     [DEPTH];
    logic                  pred_q   [DEPTH];
    logic [31:0]           value_q  [DEPTH];
    logic                  jump_q   [DEPTH];
    logic [31:0]           target_q [DEPTH];

    logic [ROB_ADDR_W-1:0] head_q, head_d;
    logic [ROB_ADDR_W-1:0] tail_q, tail_d;
    logic [ROB_ADDR_W:0]   count_q, count_d;
    logic                  flush_pending_q;
    logic                  flush_q;
    logic [31:0]           flush_pc_q;
    logic                  commit_valid_q;
    logic [ROB_ADDR_W-1:0] commit_index_q;
    logic [4:0]            commit_rd_q;
    logic [31:0]           commit_value_q;
    logic                  commit_store_q;

    logic w_flushing;
    logic w_issue;
    logic w_cdb_wr;
    logic w_lsb_wr;
    logic w_commit;
    logic w_mispredict;

    assign w_flushing   = flush_pending_q | flush_q;
    assign w_issue      = issue_valid && (count_q != FULL_COUNT) && !w_flushing;
    assign w_cdb_wr     = cdb_valid && valid_q[cdb_index] && !w_flushing;
    assign w_lsb_wr     = lsb_valid && valid_q[lsb_index] && !w_flushing;
    assign w_commit     = (count_q != '0) && valid_q[head_q] && ready_q[head_q];
    assign w_mispredict = w_commit && (type_q[head_q] == TYPE_BRANCH)
                          && (jump_q[head_q] != pred_q[head_q]);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_issue)
            tail_d = tail_q + ROB_ADDR_W'(1);
        if (w_commit)
            head_d = head_q + ROB_ADDR_W'(1);
        if (w_issue && !w_commit)
            count_d = count_q + (ROB_ADDR_W+1)'(1);
        else if (!w_issue && w_commit)
            count_d = count_q - (ROB_ADDR_W+1)'(1);
        if (w_mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state; a mispredict wipes everything, including a same-edge issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            flush_q         <= 1'b0;
            flush_pc_q      <= '0;
            commit_valid_q  <= 1'b0;
            commit_index_q  <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_store_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (w_cdb_wr)
                ready_q[cdb_index] <= 1'b1;
            if (w_lsb_wr)
                ready_q[lsb_index] <= 1'b1;
            if (w_issue) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
            end
            commit_valid_q <= w_commit;
            commit_store_q <= w_commit && (type_q[head_q] == TYPE_STORE);
            if (w_commit) begin
                commit_index_q  <= head_q;
                commit_rd_q     <= rd_q[head_q];
                commit_value_q  <= value_q[head_q];
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
            flush_pending_q <= w_mispredict;
            flush_q         <= flush_pending_q;
            if (w_mispredict) begin
                flush_pc_q <= jump_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
                for (int i = 0; i < DEPTH; i++) begin
                    valid_q[i] <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (w_issue) begin
                type_q[tail_q] <= issue_type;
                rd_q[tail_q]   <= issue_rd;
                pc_q[tail_q]   <= issue_pc;
                pred_q[tail_q] <= issue_pred_jump;
            end
            if (w_cdb_wr) begin
                value_q[cdb_index]  <= cdb_value;
                jump_q[cdb_index]   <= cdb_jump;
                target_q[cdb_index] <= cdb_target;
            end
            if (w_lsb_wr)
                value_q[lsb_index] <= lsb_value;
        end
    end

    // Operand lookup: same-cycle bus results win over stored values.
    always_comb begin
        query1_ready = 1'b0;
        query1_value = '0;
        if (valid_q[query1_index]) begin
            if (cdb_valid && cdb_index == query1_index) begin
                query1_ready = 1'b1;
                query1_value = cdb_value;
            end else if (lsb_valid && lsb_index == query1_index) begin
                query1_ready = 1'b1;
                query1_value = lsb_value;
            end else if (ready_q[query1_index]) begin
                query1_ready = 1'b1;
                query1_value = value_q[query1_index];
            end
        end
    end

    always_comb begin
        query2_ready = 1'b0;
        query2_value = '0;
        if (valid_q[query2_index]) begin
            if (cdb_valid && cdb_index == query2_index) begin
                query2_ready = 1'b1;
                query2_value = cdb_value;
            end else if (lsb_valid && lsb_index == query2_index) begin
                query2_ready = 1'b1;
                query2_value = lsb_value;
            end else if (ready_q[query2_index]) begin
                query2_ready = 1'b1;
                query2_value = value_q[query2_index];
            end
        end
    end

    assign issue_index  = tail_q;
    assign rob_full     = (count_q == FULL_COUNT);
    assign commit_valid = commit_valid_q;
    assign commit_index = commit_index_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_store = commit_store_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// =====================================================================
// tb_reorder_buffer: directed vector bench for reorder_buffer. Rev 1.0
// =====================================================================
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_type = '0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] issue_pc = '0;
    logic        issue_pred_jump = 1'b0;
    logic [5:0]  issue_index;
    logic        rob_full;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_index = '0;
    logic [31:0] cdb_value = '0;
    logic        cdb_jump = 1'b0;
    logic [31:0] cdb_target = '0;
    logic        lsb_valid = 1'b0;
    logic [5:0]  lsb_index = '0;
    logic [31:0] lsb_value = '0;
    logic [5:0]  query1_index = '0;
    logic        query1_ready;
    logic [31:0] query1_value;
    logic [5:0]  query2_index = '0;
    logic        query2_ready;
    logic [31:0] query2_value;
    logic        commit_valid;
    logic [5:0]  commit_index;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        commit_store;
    logic        flush;
    logic [31:0] flush_pc;

    int n_vec = 0;
    int n_err = 0;

    reorder_buffer #(.ROB_ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
        .issue_index(issue_index), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_value(cdb_value),
        .cdb_jump(cdb_jump), .cdb_target(cdb_target),
        .lsb_valid(lsb_valid), .lsb_index(lsb_index), .lsb_value(lsb_value),
        .query1_index(query1_index), .query1_ready(query1_ready), .query1_value(query1_value),
        .query2_index(query2_index), .query2_ready(query2_ready), .query2_value(query2_value),
        .commit_valid(commit_valid), .commit_index(commit_index), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_store(commit_store),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [1:0]  ity;
        logic [4:0]  ird;
        logic [31:0] ipc;
        logic        cv;
        logic [5:0]  ci;
        logic [31:0] cval;
        logic        lv;
        logic [5:0]  li;
        logic [31:0] lval;
        logic [5:0]  q1i;
        logic [5:0]  q2i;
        logic        e_q1r;
        logic [31:0] e_q1v;
        logic        e_q2r;
        logic [31:0] e_q2v;
        logic [5:0]  e_idx;
        logic        e_cv;
        logic [5:0]  e_ci;
        logic [4:0]  e_crd;
        logic [31:0] e_cval;
        logic        e_cst;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1;
        issue_valid = 1'b0; issue_type = '0; issue_rd = '0; issue_pc = '0; issue_pred_jump = 1'b0;
        cdb_valid = 1'b0; cdb_index = '0; cdb_value = '0; cdb_jump = 1'b0; cdb_target = '0;
        lsb_valid = 1'b0; lsb_index = '0; lsb_value = '0;
        query1_index = '0; query2_index = '0;
    endtask

    task automatic do_issue(input logic [1:0] ty, input logic [4:0] rd,
                            input logic [31:0] pc, input logic pred);
        issue_valid = 1'b1; issue_type = ty; issue_rd = rd; issue_pc = pc; issue_pred_jump = pred;
    endtask

    task automatic chk_commit(input string name, input logic ev, input logic [5:0] ei,
                              input logic [4:0] er, input logic [31:0] evl, input logic est);
        chk({name, ".commit_valid"}, {31'd0, commit_valid}, {31'd0, ev});
        if (ev) begin
            chk({name, ".commit_index"}, {26'd0, commit_index}, {26'd0, ei});
            chk({name, ".commit_rd"}, {27'd0, commit_rd}, {27'd0, er});
            chk({name, ".commit_value"}, commit_value, evl);
            chk({name, ".commit_store"}, {31'd0, commit_store}, {31'd0, est});
        end
    endtask

    initial begin
        // iv ty rd pc | cv ci cval | lv li lval | q1 q2 | q1r q1v q2r q2v | idx cv ci rd val st
        vecs[0]  = '{1'b1, 2'd0, 5'd5, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0,
                     1'b0, 32'h0, 1'b0, 32'h0, 6'd1, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 5'd6, 32'h4, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd1,
                     1'b0, 32'h0, 1'b0, 32'h0, 6'd2, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd1, 32'h22, 6'd1, 6'd0,
                     1'b1, 32'h22, 1'b0, 32'h0, 6'd2, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 6'd0, 32'h11, 1'b0, 6'd0, 32'h0, 6'd0, 6'd1,
                     1'b1, 32'h11, 1'b1, 32'h22, 6'd2, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd1, 6'd0,
                     1'b1, 32'h22, 1'b1, 32'h11, 6'd2, 1'b1, 6'd0, 5'd5, 32'h11, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd1,
                     1'b0, 32'h0, 1'b1, 32'h22, 6'd2, 1'b1, 6'd1, 5'd6, 32'h22, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 5'd0, 32'h8, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd1, 6'd2,
                     1'b0, 32'h0, 1'b0, 32'h0, 6'd3, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 5'd7, 32'hC, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd3, 6'd2,
                     1'b0, 32'h0, 1'b0, 32'h0, 6'd4, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 6'd3, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0, 6'd3, 6'd2,
                     1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 6'd4, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd2, 32'h0, 6'd5, 6'd3,
                     1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 6'd4, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd2, 6'd3,
                     1'b1, 32'h0, 1'b1, 32'hDEADBEEF, 6'd4, 1'b1, 6'd2, 5'd0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd3, 6'd2,
                     1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 6'd4, 1'b1, 6'd3, 5'd7, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd3, 6'd4,
                     1'b0, 32'h0, 1'b0, 32'h0, 6'd4, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0};

        idle();
        tick();
        tick();
        chk("reset.issue_index", {26'd0, issue_index}, 32'd0);
        chk("reset.rob_full", {31'd0, rob_full}, 32'd0);
        chk("reset.commit_valid", {31'd0, commit_valid}, 32'd0);
        chk("reset.flush", {31'd0, flush}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            issue_valid = vecs[i].iv; issue_type = vecs[i].ity; issue_rd = vecs[i].ird;
            issue_pc = vecs[i].ipc; issue_pred_jump = 1'b0;
            cdb_valid = vecs[i].cv; cdb_index = vecs[i].ci; cdb_value = vecs[i].cval;
            lsb_valid = vecs[i].lv; lsb_index = vecs[i].li; lsb_value = vecs[i].lval;
            query1_index = vecs[i].q1i; query2_index = vecs[i].q2i;
            #1;
            chk($sformatf("v%0d.query1_ready", i), {31'd0, query1_ready}, {31'd0, vecs[i].e_q1r});
            chk($sformatf("v%0d.query1_value", i), query1_value, vecs[i].e_q1v);
            chk($sformatf("v%0d.query2_ready", i), {31'd0, query2_ready}, {31'd0, vecs[i].e_q2r});
            chk($sformatf("v%0d.query2_value", i), query2_value, vecs[i].e_q2v);
            tick();
            chk($sformatf("v%0d.issue_index", i), {26'd0, issue_index}, {26'd0, vecs[i].e_idx});
            chk($sformatf("v%0d.rob_full", i), {31'd0, rob_full}, 32'd0);
            chk($sformatf("v%0d.flush", i), {31'd0, flush}, 32'd0);
            chk_commit($sformatf("v%0d", i), vecs[i].e_cv, vecs[i].e_ci, vecs[i].e_crd,
                       vecs[i].e_cval, vecs[i].e_cst);
        end

        // Taken mispredict: branch tag4 predicted not-taken, younger REG tag5.
        idle(); do_issue(2'd1, 5'd1, 32'h100, 1'b0); tick();
        chk("mp.idx_branch", {26'd0, issue_index}, 32'd5);
        idle(); do_issue(2'd0, 5'd9, 32'h104, 1'b0); tick();
        chk("mp.idx_young", {26'd0, issue_index}, 32'd6);
        idle();
        cdb_valid = 1'b1; cdb_index = 6'd4; cdb_value = 32'h104; cdb_jump = 1'b1; cdb_target = 32'h200;
        lsb_valid = 1'b1; lsb_index = 6'd5; lsb_value = 32'h99;
        tick();
        chk_commit("mp.wb", 1'b0, 6'd0, 5'd0, 32'h0, 1'b0);
        idle(); do_issue(2'd0, 5'd2, 32'h108, 1'b0); tick();
        chk_commit("mp.commit", 1'b1, 6'd4, 5'd1, 32'h104, 1'b0);
        chk("mp.commit_flush", {31'd0, flush}, 32'd0);
        chk("mp.commit_idx", {26'd0, issue_index}, 32'd0);
        idle(); do_issue(2'd0, 5'd2, 32'h10C, 1'b0); tick();
        chk("mp.flush", {31'd0, flush}, 32'd1);
        chk("mp.flush_pc", flush_pc, 32'h200);
        chk("mp.pending_idx", {26'd0, issue_index}, 32'd0);
        chk_commit("mp.pending", 1'b0, 6'd0, 5'd0, 32'h0, 1'b0);
        idle(); do_issue(2'd0, 5'd2, 32'h110, 1'b0); tick();
        chk("mp.flush_drop", {31'd0, flush}, 32'd0);
        chk("mp.flush_idx", {26'd0, issue_index}, 32'd0);
        chk_commit("mp.after", 1'b0, 6'd0, 5'd0, 32'h0, 1'b0);

        // Not-taken mispredict of a predicted-taken branch.
        idle(); do_issue(2'd1, 5'd0, 32'h300, 1'b1); tick();
        chk("nt.idx", {26'd0, issue_index}, 32'd1);
        chk_commit("nt.young_never", 1'b0, 6'd0, 5'd0, 32'h0, 1'b0);
        idle();
        cdb_valid = 1'b1; cdb_index = 6'd0; cdb_value = 32'h0; cdb_jump = 1'b0; cdb_target = 32'h999;
        tick();
        chk_commit("nt.wb", 1'b0, 6'd0, 5'd0, 32'h0, 1'b0);
        idle(); tick();
        chk_commit("nt.commit", 1'b1, 6'd0, 5'd0, 32'h0, 1'b0);
        chk("nt.commit_idx", {26'd0, issue_index}, 32'd0);
        idle(); tick();
        chk("nt.flush", {31'd0, flush}, 32'd1);
        chk("nt.flush_pc", flush_pc, 32'h304);
        idle(); tick();
        chk("nt.flush_drop", {31'd0, flush}, 32'd0);

        // rdy low freezes a pending commit pulse and blocks issue.
        idle(); do_issue(2'd0, 5'd3, 32'h400, 1'b0); tick();
        chk("rdy.idx", {26'd0, issue_index}, 32'd1);
        idle(); cdb_valid = 1'b1; cdb_index = 6'd0; cdb_value = 32'h33; tick();
        idle(); tick();
        chk_commit("rdy.commit", 1'b1, 6'd0, 5'd3, 32'h33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 1'b0; do_issue(2'd0, 5'd4, 32'h404, 1'b0); tick();
            chk_commit($sformatf("rdy.hold%0d", i), 1'b1, 6'd0, 5'd3, 32'h33, 1'b0);
            chk($sformatf("rdy.hold_idx%0d", i), {26'd0, issue_index}, 32'd1);
        end
        idle(); tick();
        chk_commit("rdy.release", 1'b0, 6'd0, 5'd0, 32'h0, 1'b0);
        chk("rdy.release_idx", {26'd0, issue_index}, 32'd1);

        // Reset in the middle of filling.
        for (int i = 0; i < 10; i++) begin
            idle(); do_issue(2'd0, 5'd1, 32'h500, 1'b0); tick();
        end
        chk("rstmid.before", {26'd0, issue_index}, 32'd11);
        idle();
        rst = 1'b0;
        #1;
        chk("rstmid.issue_index", {26'd0, issue_index}, 32'd0);
        chk("rstmid.rob_full", {31'd0, rob_full}, 32'd0);
        chk("rstmid.commit_valid", {31'd0, commit_valid}, 32'd0);
        chk("rstmid.flush", {31'd0, flush}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Fill all 64 entries, overflow, then free one slot and wrap.
        for (int i = 0; i < 64; i++) begin
            idle(); do_issue(2'd0, 5'd2, 32'h600, 1'b0); tick();
            if (i == 0)
                chk("full.first_tag", {26'd0, issue_index}, 32'd1);
            if (i == 62)
                chk("full.not_yet", {31'd0, rob_full}, 32'd0);
        end
        chk("full.rob_full", {31'd0, rob_full}, 32'd1);
        chk("full.idx_wrap", {26'd0, issue_index}, 32'd0);
        idle(); do_issue(2'd0, 5'd2, 32'h700, 1'b0); tick();
        chk("full.65th_idx", {26'd0, issue_index}, 32'd0);
        chk("full.65th_full", {31'd0, rob_full}, 32'd1);
        idle(); do_issue(2'd0, 5'd2, 32'h700, 1'b0);
        cdb_valid = 1'b1; cdb_index = 6'd0; cdb_value = 32'hAA; tick();
        chk("full.wb_full", {31'd0, rob_full}, 32'd1);
        chk_commit("full.wb", 1'b0, 6'd0, 5'd0, 32'h0, 1'b0);
        idle(); do_issue(2'd0, 5'd2, 32'h700, 1'b0); tick();
        chk_commit("full.commit", 1'b1, 6'd0, 5'd2, 32'hAA, 1'b0);
        chk("full.commit_idx", {26'd0, issue_index}, 32'd0);
        chk("full.commit_full", {31'd0, rob_full}, 32'd0);
        idle(); do_issue(2'd0, 5'd2, 32'h704, 1'b0); tick();
        chk("full.wrap_idx", {26'd0, issue_index}, 32'd1);
        chk("full.wrap_full", {31'd0, rob_full}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
